// File: rtl/pipe_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_if
// Bundles the signals between the core datapath and the pipeline hazard
// controller. The core (master) drives the hazard sources. The controller
// (slave) drives the stall, flush, forward-select and status outputs.
//
// Hazard sources (core -> controller):
//   branch_taken, ex_mem_to_reg, ex_mem_write, dmem_ready, halt_req, resume,
//   id_rs1[4:0], id_rs2[4:0], id_rs1_used, id_rs2_used,
//   wb_dest_reg_sel[4:0], wb_alu_to_reg, wb_mem_to_reg
// Controls (controller -> core):
//   stall_fetch, stall_read, flush_id, fwd_sel1[1:0], fwd_sel2[1:0],
//   halted, mem_timeout, stall_cycles[CNT_W-1:0]
// ---------------------------------------------------------------------------
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             branch_taken;
  logic             ex_mem_to_reg;
  logic             ex_mem_write;
  logic             dmem_ready;
  logic             halt_req;
  logic             resume;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_rs1_used;
  logic             id_rs2_used;
  logic [4:0]       wb_dest_reg_sel;
  logic             wb_alu_to_reg;
  logic             wb_mem_to_reg;

  logic             stall_fetch;
  logic             stall_read;
  logic             flush_id;
  logic [1:0]       fwd_sel1;
  logic [1:0]       fwd_sel2;
  logic             halted;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output branch_taken, ex_mem_to_reg, ex_mem_write, dmem_ready, halt_req,
           resume, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           wb_dest_reg_sel, wb_alu_to_reg, wb_mem_to_reg,
    input  stall_fetch, stall_read, flush_id, fwd_sel1, fwd_sel2, halted,
           mem_timeout, stall_cycles
  );

  modport slave (
    input  branch_taken, ex_mem_to_reg, ex_mem_write, dmem_ready, halt_req,
           resume, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           wb_dest_reg_sel, wb_alu_to_reg, wb_mem_to_reg,
    output stall_fetch, stall_read, flush_id, fwd_sel1, fwd_sel2, halted,
           mem_timeout, stall_cycles
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
// Central controller for the 3-stage IF/ID - EX - WB core. It does the
// following:
//   - sequences the execute stage with a RUN / MEM_WAIT / FLUSH / HALT FSM,
//   - inserts one-cycle load-use bubbles,
//   - drives the WB->EX forward selects,
//   - counts stalled fetch cycles with a saturating counter.
//
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high; clears all state
//   bus   : pipe_hazard_ctrl_if.slave (hazard sources in, controls out)
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int FLUSH_SLOTS = 1,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               reset,
  pipe_hazard_ctrl_if.slave  bus
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FLUSH    = 2'd2,
    ST_HALT     = 2'd3
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [1:0]        r_flush_cnt, w_flush_cnt_nxt;
  logic [WAIT_W-1:0] r_wait_cnt, w_wait_cnt_nxt;
  logic              r_bubble, w_bubble_nxt;
  logic [CNT_W-1:0]  r_stall_cycles;

  logic w_rs1_match, w_rs2_match, w_load_use, w_mem_access, w_timeout;
  logic w_stall;

  // x0 is hardwired to zero, so a WB write to it is never a real producer.
  assign w_rs1_match  = (bus.wb_dest_reg_sel != 5'd0) && (bus.id_rs1 == bus.wb_dest_reg_sel);
  assign w_rs2_match  = (bus.wb_dest_reg_sel != 5'd0) && (bus.id_rs2 == bus.wb_dest_reg_sel);
  assign w_load_use   = bus.wb_mem_to_reg &&
                        ((bus.id_rs1_used && w_rs1_match) || (bus.id_rs2_used && w_rs2_match));
  assign w_mem_access = bus.ex_mem_to_reg || bus.ex_mem_write;

  // Forward selects: load data takes precedence over an ALU result.
  always_comb begin
    bus.fwd_sel1 = 2'b00;
    bus.fwd_sel2 = 2'b00;
    if (w_rs1_match) begin
      if (bus.wb_mem_to_reg)      bus.fwd_sel1 = 2'b10;
      else if (bus.wb_alu_to_reg) bus.fwd_sel1 = 2'b01;
    end
    if (w_rs2_match) begin
      if (bus.wb_mem_to_reg)      bus.fwd_sel2 = 2'b10;
      else if (bus.wb_alu_to_reg) bus.fwd_sel2 = 2'b01;
    end
  end

  // Next-state logic. Only the highest-priority RUN event acts.
  always_comb begin
    w_state_nxt     = r_state;
    w_flush_cnt_nxt = r_flush_cnt;
    w_wait_cnt_nxt  = r_wait_cnt;
    w_bubble_nxt    = 1'b0;
    w_timeout       = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (bus.halt_req) begin
          w_state_nxt = ST_HALT;
        end else if (bus.branch_taken) begin
          w_state_nxt     = ST_FLUSH;
          w_flush_cnt_nxt = 2'(FLUSH_SLOTS);
        end else if (w_mem_access && !bus.dmem_ready) begin
          w_state_nxt    = ST_MEM_WAIT;
          w_wait_cnt_nxt = WAIT_W'(1);
        end else if (w_load_use && !r_bubble) begin
          // The bubble is never re-armed by a hazard that is still visible
          // while the bubble itself is active. This keeps it to one cycle.
          w_bubble_nxt = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (bus.dmem_ready) begin
          w_state_nxt = ST_RUN;
        end else if (r_wait_cnt == WAIT_W'(MEM_TIMEOUT)) begin
          w_state_nxt = ST_HALT;
          w_timeout   = 1'b1;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + 1'b1;
        end
      end
      ST_FLUSH: begin
        if (r_flush_cnt <= 2'd1) w_state_nxt = ST_RUN;
        else                     w_flush_cnt_nxt = r_flush_cnt - 2'd1;
      end
      ST_HALT: begin
        if (bus.resume) begin
          w_state_nxt     = ST_RUN;
          w_flush_cnt_nxt = 2'd0;
          w_wait_cnt_nxt  = '0;
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_RUN;
      r_flush_cnt <= 2'd0;
      r_wait_cnt  <= '0;
      r_bubble    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
      r_wait_cnt  <= w_wait_cnt_nxt;
      r_bubble    <= w_bubble_nxt;
    end
  end

  // Moore decodes of state (plus the load-use bubble in RUN).
  assign w_stall = (r_state == ST_RUN) ? r_bubble
                                       : ((r_state == ST_MEM_WAIT) || (r_state == ST_HALT));

  assign bus.stall_fetch  = w_stall;
  assign bus.stall_read   = w_stall;
  assign bus.flush_id     = (r_state == ST_FLUSH) || (r_state == ST_HALT);
  assign bus.halted       = (r_state == ST_HALT);
  assign bus.mem_timeout  = w_timeout;
  assign bus.stall_cycles = r_stall_cycles;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                    r_stall_cycles <= '0;
    else if (w_stall && (r_stall_cycles != '1))   r_stall_cycles <= r_stall_cycles + 1'b1;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central pipeline controller for the 3-stage IF/ID – EX – WB core.
- Sequences the execute stage. It generates `stall_read` and the fetch stall, squashes wrong-path instructions after a taken branch, waits on the data memory, inserts load-use bubbles and halts the core on exceptions.
- It also drives the WB→EX operand-forward selects and keeps a saturating stall-cycle counter for trace logging.

Parameters:
- FLUSH_SLOTS, 1, number of IF/ID slots squashed after `branch_taken` (1..3).
- MEM_TIMEOUT, 16, max cycles waiting on `dmem_ready` before a timeout (≥2).
- CNT_W, 16, width of `stall_cycles`.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high; all state cleared.
- branch_taken  in  1  execute-stage branch/jump resolved taken.
- ex_mem_to_reg  in  1  load in EX.
- ex_mem_write  in  1  store in EX.
- dmem_ready  in  1  data memory accepted/returned the access this cycle.
- halt_req  in  1  illegal instruction / exception from decode.
- resume  in  1  single-cycle pulse; leaves HALT.
- id_rs1  in  5  source reg 1 of the instruction in IF/ID.
- id_rs2  in  5  source reg 2 of the instruction in IF/ID.
- id_rs1_used  in  1  instruction reads rs1.
- id_rs2_used  in  1  instruction reads rs2.
- wb_dest_reg_sel  in  5  destination register of the instruction in WB.
- wb_alu_to_reg  in  1  WB writes an ALU result.
- wb_mem_to_reg  in  1  WB writes load data.
- stall_fetch  out  1  hold PC and IF/ID.
- stall_read  out  1  hold the execute stage (maps to the execute `stall_read`).
- flush_id  out  1  convert the IF/ID instruction into a bubble.
- fwd_sel1  out  2  operand-1 source: 00 register file, 01 WB ALU result, 10 WB load data.
- fwd_sel2  out  2  operand-2 source, same encoding.
- halted  out  1  core halted.
- mem_timeout  out  1  one-cycle pulse when a memory wait times out.
- stall_cycles  out  CNT_W  saturating count of cycles with `stall_fetch`=1.

Behaviour:
- States: RUN(0), MEM_WAIT(1), FLUSH(2), HALT(3). Registered state.
- stall/flush/halted outputs are Moore decodes of the state (plus the load-use bubble flag). `fwd_sel` is combinational.
- Reset values:
  - state=RUN, `stall_fetch`=0, `stall_read`=0, `flush_id`=0, `halted`=0, `mem_timeout`=0, `stall_cycles`=0.
  - Flush counter=0, wait counter=0, bubble flag=0.
- Transitions out of RUN, sampled at the rising edge in priority order (only the highest-priority event acts):
  - `halt_req` → HALT.
  - `branch_taken` → FLUSH, flush counter loaded with FLUSH_SLOTS.
  - (`ex_mem_to_reg` | `ex_mem_write`) & !`dmem_ready` → MEM_WAIT, wait counter=1.
  - Load-use hazard: `wb_mem_to_reg` & `wb_dest_reg_sel`≠0 & ((`id_rs1_used` & `id_rs1`==`wb_dest_reg_sel`) | (`id_rs2_used` & `id_rs2`==`wb_dest_reg_sel`)).
    - Sets the bubble flag for exactly one cycle; state stays RUN.
- RUN outputs:
  - `stall_fetch`=`stall_read`=bubble flag.
  - `flush_id`=0.
- MEM_WAIT:
  - Outputs: `stall_fetch`=1, `stall_read`=1.
  - `dmem_ready`=1 → RUN next cycle.
  - Otherwise the wait counter increments. When the counter equals MEM_TIMEOUT with `dmem_ready`=0 → HALT, with `mem_timeout`=1 for exactly that transition cycle.
  - `halt_req` in MEM_WAIT is ignored until the access completes.
- FLUSH:
  - Outputs: `flush_id`=1, `stall_fetch`=0, `stall_read`=0.
  - Counter decrements each cycle; when it reaches 1 → RUN.
  - `flush_id` is therefore high for exactly FLUSH_SLOTS cycles, starting the cycle after `branch_taken`.
  - `branch_taken` during FLUSH is ignored (the instruction is being squashed).
  - `halt_req` during FLUSH is ignored (the squashed instruction cannot raise exceptions).
- HALT:
  - Outputs: `stall_fetch`=1, `stall_read`=1, `flush_id`=1, `halted`=1.
  - `resume` → RUN, with all counters and the bubble flag cleared. `resume` outside HALT has no effect.
- Forwarding (combinational; the WB match condition is `wb_dest_reg_sel`≠0 and `wb_dest_reg_sel`==`id_rsN`, N=1,2):
  - `fwd_selN`=01 if `wb_alu_to_reg` and the WB match condition holds.
  - `fwd_selN`=10 if `wb_mem_to_reg` and the WB match condition holds.
  - Otherwise 00. If both `wb_alu_to_reg` and `wb_mem_to_reg` are set, 10 wins.
  - x0 is never forwarded.
- `stall_cycles`: increments on every rising edge where `stall_fetch`=1; saturates at all-ones; cleared only by `reset`.
- Reset mid-operation (any state): immediate return to RUN with all outputs at reset values, without waiting for a clock edge.

Test Plan:
- Reset, then `branch_taken`=1 for one cycle with FLUSH_SLOTS=1 → `flush_id`=1 for exactly one cycle; `stall_fetch`=0 throughout; state back to RUN.
- `ex_mem_to_reg`=1, `dmem_ready`=0 for 3 cycles, then 1 → `stall_read`=`stall_fetch`=1 for 3 cycles; `stall_cycles`=3.
- `ex_mem_write`=1, `dmem_ready` held 0 with MEM_TIMEOUT=16 → `mem_timeout` single pulse; `halted`=1; `resume` pulse → `halted`=0, RUN.
- Load-use hazard, `wb_mem_to_reg`=1, `wb_dest_reg_sel`=5, `id_rs2`=5, `id_rs2_used`=1 → one-cycle `stall_read`=1 and `fwd_sel2`=10; with `wb_dest_reg_sel`=0 → no stall, `fwd_sel2`=00.
- `halt_req`=1 and `branch_taken`=1 in the same RUN cycle → HALT, no FLUSH; `flush_id`=1 and `halted`=1 persist until `resume`.
- Assert `reset` asynchronously mid-MEM_WAIT → outputs zero before the next clk edge; `stall_cycles`=0.
